// File: rtl/timer_pkg.sv
// Shared types and defaults for the interval timer controller and its counter datapath.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } timer_state_t;

  localparam int TIMER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit synchronous up-counter; clr has priority over en.
module counter_core
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences counter_core through one-shot or periodic runs
// up to a captured terminal value.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  timer_state_t     state;
  timer_state_t     state_next;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             term_c;
  logic             clr_c;
  logic             en_c;
  logic             capture_c;

  counter_core #(
    .WIDTH (WIDTH)
  ) u_counter_core (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_c),
    .en    (en_c),
    .q     (count)
  );

  // Terminal decode uses registered count and limit only, so tick cannot glitch on inputs.
  always_comb begin
    term_c = (count == limit_q);
    tick   = (state == RUN) && term_c;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter control; stop outranks both start and terminal.
  always_comb begin
    state_next = state;
    clr_c      = 1'b0;
    en_c       = 1'b0;
    capture_c  = 1'b0;
    unique case (state)
      IDLE: begin
        clr_c = 1'b1;
        if (start && !stop) begin
          capture_c  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          clr_c      = 1'b1;
          state_next = IDLE;
        end else if (term_c) begin
          if (periodic_q) begin
            clr_c = 1'b1;
          end else begin
            state_next = DONE;
          end
        end else begin
          en_c = 1'b1;
        end
      end
      DONE: begin
        clr_c      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        clr_c      = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Run parameters are frozen at the accepting edge and ignored afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else if (capture_c) begin
      limit_q    <= limit;
      periodic_q <= periodic;
    end
  end

  // busy/done track the state they describe, registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: run-level model compared every cycle,
// plus directed cycle-accurate expectations.
module tb_interval_timer_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         tick;
  logic         done;

  int n_total = 0;
  int n_pass  = 0;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Run-level model: 0 = idle, 1 = running (n cycles since run began), 2 = done cycle.
  int m_mode = 0;
  int m_n    = 0;
  int m_lim  = 0;
  bit m_per  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0;
      m_n    = 0;
    end else begin
      case (m_mode)
        0: if (start && !stop) begin
             m_mode = 1; m_n = 0; m_lim = int'(limit); m_per = periodic;
           end
        1: if (stop) m_mode = 0;
           else if (!m_per && m_n == m_lim) m_mode = 2;
           else m_n++;
        default: m_mode = 0;
      endcase
    end
  end

  function automatic int exp_count();
    if (m_mode == 1) return m_per ? (m_n % (m_lim + 1)) : m_n;
    if (m_mode == 2) return m_lim;
    return 0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_count", int'(count), exp_count());
      check("model_busy", int'(busy), int'(m_mode == 1));
      check("model_tick", int'(tick), int'(m_mode == 1 && exp_count() == m_lim));
      check("model_done", int'(done), int'(m_mode == 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string name, input int c, input int b, input int t, input int d);
    check({name, "_count"}, int'(count), c);
    check({name, "_busy"}, int'(busy), b);
    check({name, "_tick"}, int'(tick), t);
    check({name, "_done"}, int'(done), d);
  endtask

  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    outs("reset", 0, 0, 0, 0);
    cyc();

    // One-shot, limit 3
    start = 1'b1; limit = 4'd3; periodic = 1'b0;
    cyc();                       // cycle 1
    start = 1'b0;
    outs("os3_c1", 0, 1, 0, 0);
    cyc(); cyc(); cyc();         // cycle 4
    outs("os3_c4", 3, 1, 1, 0);
    cyc();                       // cycle 5
    outs("os3_c5", 3, 0, 0, 1);
    cyc();                       // cycle 6
    outs("os3_c6", 0, 0, 0, 0);
    cyc();

    // Periodic, limit 2; start held with a new limit during the run is ignored
    start = 1'b1; limit = 4'd2; periodic = 1'b1;
    cyc();                       // cycle 1
    limit = 4'd9; periodic = 1'b0;
    cyc(); cyc();                // cycle 3
    outs("per2_c3", 2, 1, 1, 0);
    cyc();                       // cycle 4
    outs("per2_c4", 0, 1, 0, 0);
    cyc(); cyc();                // cycle 6
    outs("per2_c6", 2, 1, 1, 0);
    cyc();                       // cycle 7
    start = 1'b0; stop = 1'b1;
    cyc();                       // cycle 8
    stop = 1'b0;
    outs("per2_c8", 0, 0, 0, 0);
    cyc();

    // One-shot, limit 0
    start = 1'b1; limit = 4'd0; periodic = 1'b0;
    cyc();
    start = 1'b0;
    outs("os0_c1", 0, 1, 1, 0);
    cyc();
    outs("os0_c2", 0, 0, 0, 1);
    cyc();
    outs("os0_c3", 0, 0, 0, 0);

    // Periodic, limit 0: tick every run cycle
    start = 1'b1; periodic = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("per0_tick", int'(tick), 1);
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();

    // Periodic, full-range limit 15
    start = 1'b1; limit = 4'd15; periodic = 1'b1;
    cyc();                       // cycle 1
    start = 1'b0;
    repeat (15) cyc();           // cycle 16
    outs("per15_c16", 15, 1, 1, 0);
    cyc();                       // cycle 17
    outs("per15_c17", 0, 1, 0, 0);
    repeat (15) cyc();           // cycle 32
    outs("per15_c32", 15, 1, 1, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // start and stop together in idle: stays idle
    start = 1'b1; stop = 1'b1; limit = 4'd1;
    cyc();
    outs("ss_idle", 0, 0, 0, 0);
    start = 1'b0; stop = 1'b0;
    cyc();

    // stop coincident with tick in one-shot
    start = 1'b1; limit = 4'd2; periodic = 1'b0;
    cyc();                       // cycle 1
    start = 1'b0;
    cyc(); cyc();                // cycle 3
    outs("stoptick_c3", 2, 1, 1, 0);
    stop = 1'b1;
    cyc();                       // cycle 4
    stop = 1'b0;
    outs("stoptick_c4", 0, 0, 0, 0);
    cyc();
    outs("stoptick_c5", 0, 0, 0, 0);

    // Back-to-back one-shot, start held through DONE
    start = 1'b1; limit = 4'd1; periodic = 1'b0;
    cyc();                       // cycle 1
    cyc();                       // cycle 2
    outs("b2b_c2", 1, 1, 1, 0);
    cyc();                       // cycle 3
    outs("b2b_c3", 1, 0, 0, 1);
    cyc();                       // cycle 4
    outs("b2b_c4", 0, 0, 0, 0);
    cyc();                       // cycle 5
    start = 1'b0;
    outs("b2b_c5", 0, 1, 0, 0);
    repeat (4) cyc();

    // Async reset mid-run at count 5
    start = 1'b1; limit = 4'd9; periodic = 1'b0;
    cyc();                       // cycle 1
    start = 1'b0;
    repeat (5) cyc();            // cycle 6
    outs("prerst", 5, 1, 0, 0);
    #2 reset = 1'b1;
    #1 outs("async_rst", 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    cyc();
    outs("post_rst", 0, 0, 0, 0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
